// File: rtl/mem_arbiter.sv
// Two-master arbiter (CPU read/write, device read-only) in front of one shared memory port.
// Round-robin on simultaneous requests; every access takes MEM_LAT cycles plus one DONE cycle.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        MIO_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dev_req,
  input  logic [31:0] dev_addr,
  output logic        dev_ack,
  output logic [31:0] dev_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     cur_state;
  state_t     next_state;
  logic [2:0] cnt;
  logic       we_q;
  logic       dev_prio;   // device wins the next tie
  logic       any_req;
  logic       pick_dev;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    next_state = cur_state;
    any_req    = CPU_MIO | dev_req;
    pick_dev   = dev_req & (~CPU_MIO | dev_prio);
    case (cur_state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  if (cnt == 3'd1) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and pulses default low each cycle; they are raised only on the transition that needs them.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      cur_state <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      dev_prio  <= 1'b0;
      grant     <= 1'b0;
      MIO_ready <= 1'b0;
      dev_ack   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
    end else begin
      cur_state <= next_state;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      MIO_ready <= 1'b0;
      dev_ack   <= 1'b0;
      case (cur_state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick_dev;
            dev_prio  <= ~pick_dev;
            we_q      <= ~pick_dev & cpu_we;
            mem_en    <= 1'b1;
            mem_we    <= ~pick_dev & cpu_we;
            mem_addr  <= pick_dev ? dev_addr : cpu_addr;
            mem_wdata <= pick_dev ? '0 : cpu_wdata;
            cnt       <= LAT;
          end
        end
        ACCESS: begin
          cnt <= cnt - 3'd1;
          // Last access cycle: read data is valid now, so capture it as DONE begins.
          if (cnt == 3'd1) begin
            if (grant) begin
              dev_ack   <= 1'b1;
              dev_rdata <= mem_rdata;
            end else begin
              MIO_ready <= 1'b1;
              if (!we_q) cpu_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin rule, fixed latency, read-data bookkeeping).
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CPU_MIO = 1'b0, cpu_we = 1'b0, dev_req = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dev_addr = '0, mem_rdata = '0;
  logic        MIO_ready, dev_ack, mem_en, mem_we, grant;
  logic [31:0] cpu_rdata, dev_rdata, mem_addr, mem_wdata;
  logic [1:0]  state;

  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = '0;
  logic        dev_req_1 = 1'b0, dev_req_7 = 1'b0;
  logic [31:0] mem_rdata_1 = 32'h1111_0001, mem_rdata_7 = 32'h7777_0007;
  logic        rdy_1, ack_1, en_1, we_1, gnt_1, rdy_7, ack_7, en_7, we_7, gnt_7;
  logic [31:0] crd_1, drd_1, ma_1, mw_1, crd_7, drd_7, ma_7, mw_7;
  logic [1:0]  st_1, st_7;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_cyc = 0;
  logic in_done = 1'b0;
  logic tie_dev = 1'b0;
  logic [31:0] cpu_exp = '0, dev_exp = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .MIO_ready(MIO_ready), .cpu_rdata(cpu_rdata), .dev_req(dev_req),
    .dev_addr(dev_addr), .dev_ack(dev_ack), .dev_rdata(dev_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant(grant), .state(state)
  );

  mem_arbiter #(.MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset), .CPU_MIO(zero_bit), .cpu_we(zero_bit), .cpu_addr(zero_word),
    .cpu_wdata(zero_word), .MIO_ready(rdy_1), .cpu_rdata(crd_1), .dev_req(dev_req_1),
    .dev_addr(zero_word), .dev_ack(ack_1), .dev_rdata(drd_1), .mem_en(en_1),
    .mem_we(we_1), .mem_addr(ma_1), .mem_wdata(mw_1), .mem_rdata(mem_rdata_1),
    .grant(gnt_1), .state(st_1)
  );

  mem_arbiter #(.MEM_LAT(7)) dut_lat7 (
    .clk(clk), .reset(reset), .CPU_MIO(zero_bit), .cpu_we(zero_bit), .cpu_addr(zero_word),
    .cpu_wdata(zero_word), .MIO_ready(rdy_7), .cpu_rdata(crd_7), .dev_req(dev_req_7),
    .dev_addr(zero_word), .dev_ack(ack_7), .dev_rdata(drd_7), .mem_en(en_7),
    .mem_we(we_7), .mem_addr(ma_7), .mem_wdata(mw_7), .mem_rdata(mem_rdata_7),
    .grant(gnt_7), .state(st_7)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
  endfunction

  // Memory stand-in: read data is valid only in the window around the MEM_LAT-th edge after mem_en.
  int          pcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  always @(negedge clk) begin
    if (mem_en) begin
      pend  = 1'b1;
      pcnt  = LAT - 1;
      paddr = mem_addr;
    end
    if (pend && pcnt == 0) begin
      mem_rdata = mem_f(paddr);
      pend      = 1'b0;
    end else begin
      if (pend) pcnt--;
      mem_rdata = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic model_pick(input logic c, input logic d);
    return d && (!c || tie_dev);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    in_done = 1'b0;
    tie_dev = 1'b0;
    cpu_exp = '0;
    dev_exp = '0;
  endtask

  // Requests for the coming IDLE cycle are already on the pins; walk the transaction and check it.
  task automatic observe_txn(input logic exp_dev, input logic exp_we, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input string tag);
    int start;
    if (in_done) tick();
    start = cyc;
    checks++;
    if (state !== 2'd0 || MIO_ready !== 1'b0 || dev_ack !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: state=%0d rdy=%b ack=%b en=%b, required 0 0 0 0", tag, state, MIO_ready, dev_ack, mem_en);
    end
    tick();
    checks++;
    if (state !== 2'd1 || mem_en !== 1'b1 || mem_we !== exp_we || mem_addr !== exp_addr || grant !== exp_dev) begin
      errors++;
      $display("FAIL %s issue: state=%0d en=%b we=%b addr=%h grant=%b, required 1 1 %b %h %b",
               tag, state, mem_en, mem_we, mem_addr, grant, exp_we, exp_addr, exp_dev);
    end
    if (exp_we) begin
      checks++;
      if (mem_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL %s wdata: got %h required %h", tag, mem_wdata, exp_wdata);
      end
    end
    cpu_addr  = $urandom;
    dev_addr  = $urandom;
    cpu_wdata = $urandom;
    cpu_we    = 1'($urandom);
    for (int c = 2; c <= LAT; c++) begin
      tick();
      checks++;
      if (state !== 2'd1 || mem_en !== 1'b0 || mem_we !== 1'b0 || MIO_ready !== 1'b0 || dev_ack !== 1'b0) begin
        errors++;
        $display("FAIL %s access%0d: state=%0d en=%b we=%b rdy=%b ack=%b, required 1 0 0 0 0",
                 tag, c, state, mem_en, mem_we, MIO_ready, dev_ack);
      end
    end
    tick();
    if (!exp_we) begin
      if (exp_dev) dev_exp = mem_f(exp_addr);
      else         cpu_exp = mem_f(exp_addr);
    end
    checks++;
    if (state !== 2'd2 || MIO_ready !== !exp_dev || dev_ack !== exp_dev || cyc - start != LAT + 1 ||
        cpu_rdata !== cpu_exp || dev_rdata !== dev_exp) begin
      errors++;
      $display("FAIL %s done: state=%0d rdy=%b ack=%b lat=%0d cpu_rdata=%h dev_rdata=%h, required 2 %b %b %0d %h %h",
               tag, state, MIO_ready, dev_ack, cyc - start, cpu_rdata, dev_rdata,
               !exp_dev, exp_dev, LAT + 1, cpu_exp, dev_exp);
    end
    ready_cyc = cyc;
    tie_dev   = !exp_dev;
    in_done   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 2'd0 || grant !== 1'b0 || MIO_ready !== 1'b0 || dev_ack !== 1'b0 || mem_en !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0 || dev_rdata !== '0) begin
      errors++;
      $display("FAIL reset: state=%0d grant=%b rdy=%b ack=%b en=%b we=%b addr=%h wd=%h crd=%h drd=%h, required all zero",
               state, grant, MIO_ready, dev_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dev_rdata);
    end
  endtask

  task automatic test_cpu_rw();
    CPU_MIO = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    observe_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, "cpu_read");
    checks++;
    if (cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_read_data: got %h required %h", cpu_rdata, 32'hDEAD_BEEF);
    end
    cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h1234_5678;
    observe_txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, "cpu_write");
    CPU_MIO = 1'b0;
  endtask

  task automatic test_tie();
    int cpu_done;
    do_reset();
    CPU_MIO = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    dev_req = 1'b1; dev_addr = 32'h0000_0200;
    observe_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, "tie_cpu");
    cpu_done = ready_cyc;
    CPU_MIO  = 1'b0; dev_addr = 32'h0000_0200;
    observe_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, "tie_dev");
    checks++;
    if (ready_cyc - cpu_done != 4) begin
      errors++;
      $display("FAIL tie_gap: dev_ack %0d cycles after MIO_ready, required 4", ready_cyc - cpu_done);
    end
    dev_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    CPU_MIO = 1'b1; dev_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b0;
      cpu_addr = 32'h0000_1000 + 32'(i * 4);
      dev_addr = 32'h0000_2000 + 32'(i * 4);
      observe_txn(1'(i % 2), 1'b0, (i % 2) ? dev_addr : cpu_addr, 32'h0, "b2b");
    end
    CPU_MIO = 1'b0; dev_req = 1'b0;
  endtask

  task automatic test_random();
    logic c_on, d_on, win, we;
    logic [31:0] ca, da, wd;
    c_on = 1'b0; d_on = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!c_on && $urandom_range(0, 1) == 1) c_on = 1'b1;
      if (!d_on && $urandom_range(0, 1) == 1) d_on = 1'b1;
      if (!c_on && !d_on) c_on = 1'b1;
      ca = $urandom; da = $urandom; wd = $urandom; we = 1'($urandom);
      CPU_MIO = c_on; dev_req = d_on; cpu_addr = ca; dev_addr = da; cpu_wdata = wd; cpu_we = we;
      win = model_pick(c_on, d_on);
      observe_txn(win, !win && we, win ? da : ca, wd, "random");
      if (win) d_on = 1'b0;
      else     c_on = 1'b0;
      CPU_MIO = c_on; dev_req = d_on;
    end
    CPU_MIO = 1'b0; dev_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dev_req = 1'b1; dev_addr = 32'h0000_0300;
    observe_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, "pre_abort");
    dev_addr = 32'h0000_0400;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 2'd0 || dev_ack !== 1'b0 || dev_rdata !== '0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL abort: state=%0d ack=%b drd=%h en=%b, required 0 0 0 0", state, dev_ack, dev_rdata, mem_en);
    end
    reset = 1'b0; dev_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dev_ack !== 1'b0 || state !== 2'd0) begin
        errors++;
        $display("FAIL abort_quiet: ack=%b state=%0d, required 0 0", dev_ack, state);
      end
    end
    in_done = 1'b0; tie_dev = 1'b0; cpu_exp = '0; dev_exp = '0;
  endtask

  task automatic test_latency_extremes();
    int seen_1, seen_7, n_1, n_7;
    seen_1 = -1; seen_7 = -1; n_1 = 0; n_7 = 0;
    dev_req_1 = 1'b1; dev_req_7 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack_1 === 1'b1) begin
        n_1++;
        if (seen_1 < 0) seen_1 = k;
        dev_req_1 = 1'b0;
      end
      if (ack_7 === 1'b1) begin
        n_7++;
        if (seen_7 < 0) seen_7 = k;
        dev_req_7 = 1'b0;
      end
    end
    dev_req_1 = 1'b0; dev_req_7 = 1'b0;
    checks++;
    if (seen_1 != 2 || n_1 != 1 || drd_1 !== 32'h1111_0001) begin
      errors++;
      $display("FAIL lat1: ack cycle=%0d pulses=%0d rdata=%h, required 2 1 %h", seen_1, n_1, drd_1, 32'h1111_0001);
    end
    checks++;
    if (seen_7 != 8 || n_7 != 1 || drd_7 !== 32'h7777_0007) begin
      errors++;
      $display("FAIL lat7: ack cycle=%0d pulses=%0d rdata=%h, required 8 1 %h", seen_7, n_7, drd_7, 32'h7777_0007);
    end
  endtask

  initial begin
    test_reset();
    test_latency_extremes();
    test_cpu_rw();
    test_tie();
    test_back_to_back();
    do_reset();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL be the fixed memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port CPU_MIO  input  1  SHALL be the CPU memory/IO request, held high until MIO_ready is seen.
REQ-005 Port cpu_we  input  1  SHALL be the CPU write strobe (1 = write, 0 = read).
REQ-006 Port cpu_addr  input  32  SHALL be the CPU byte address.
REQ-007 Port cpu_wdata  input  32  SHALL be the CPU write data.
REQ-008 Port MIO_ready  output  1  SHALL be a one-cycle completion pulse to the CPU.
REQ-009 Port cpu_rdata  output  32  SHALL be the registered read data for the CPU.
REQ-010 Port dev_req  input  1  SHALL be the read-only device (VGA/DMA) request, held until dev_ack.
REQ-011 Port dev_addr  input  32  SHALL be the device byte address.
REQ-012 Port dev_ack  output  1  SHALL be a one-cycle completion pulse to the device.
REQ-013 Port dev_rdata  output  32  SHALL be the registered read data for the device.
REQ-014 Port mem_en, mem_we  output  1 each  SHALL be the shared-memory access strobe and write enable.
REQ-015 Port mem_addr, mem_wdata  output  32 each  SHALL be the shared-memory address and write data.
REQ-016 Port mem_rdata  input  32  SHALL be the shared-memory read data.
REQ-017 Port grant  output  1  SHALL indicate the current/last owner (0 = CPU, 1 = device).
REQ-018 Port state  output  2  SHALL expose the FSM encoding (IDLE=0, ACCESS=1, DONE=2).

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, DONE; encoding 3 unused and SHALL return to IDLE next cycle.
REQ-020 In IDLE with any request sampled, arbiter SHALL latch owner, address, we (0 for device), wdata, and move to ACCESS.
REQ-021 Both requests in the same IDLE cycle SHALL be resolved round-robin: grant the requester not granted last; after reset the CPU wins first.
REQ-022 mem_en SHALL be high for exactly the first ACCESS cycle, with mem_we/mem_addr/mem_wdata driven from latched values; mem_we SHALL be 0 whenever mem_en is 0.
REQ-023 ACCESS SHALL last exactly MEM_LAT cycles (3-bit down-counter), for reads and writes alike.
REQ-024 In DONE, arbiter SHALL capture mem_rdata into the owner's rdata register (reads only), pulse the owner's ready/ack for one cycle, and return to IDLE.
REQ-025 Latency: request sampled in IDLE cycle 0 -> ready/ack in cycle MEM_LAT+1 (cycle 3 at default).
REQ-026 Request or address changes during ACCESS/DONE SHALL be ignored; the latched transaction completes.
REQ-027 Requester SHALL drop its request the cycle after ready/ack; a request still high in the following IDLE cycle SHALL be treated as a new transaction.
REQ-028 Non-owner rdata register SHALL hold its value; writes SHALL NOT update cpu_rdata.
REQ-029 Back-to-back: with both requests held continuously, grants SHALL alternate CPU, device, CPU, ...

Reset
REQ-030 Reset SHALL force state=IDLE, grant=0 (CPU last-served priority cleared so CPU wins next tie), counter=0, MIO_ready=dev_ack=mem_en=mem_we=0, mem_addr=mem_wdata=cpu_rdata=dev_rdata=0.
REQ-031 Reset asserted mid-ACCESS or DONE SHALL abort the transaction with no ready/ack pulse in the cycle following reset.

Verification
REQ-032 CPU read 0x0000_0010, memory returns 0xDEADBEEF, MEM_LAT=2 -> mem_en in cycle 1 only, MIO_ready and cpu_rdata=0xDEADBEEF in cycle 3.
REQ-033 CPU write 0x0000_0020 data 0x12345678 -> mem_en=mem_we=1 one cycle with that addr/data, MIO_ready cycle 3, cpu_rdata unchanged.
REQ-034 CPU_MIO and dev_req rise together after reset -> CPU served first, device second; grant 0 then 1; dev_ack 4 cycles after MIO_ready at MEM_LAT=2.
REQ-035 Both held high for 4 transactions -> grant sequence 0,1,0,1, no cycle with two ready pulses.
REQ-036 Reset asserted in second ACCESS cycle of a device read -> state=0, dev_ack never pulses, dev_rdata=0.
REQ-037 MEM_LAT=1 and MEM_LAT=7 builds, single device read -> dev_ack in cycle 2 and cycle 8 respectively.
